// File: rtl/s_axis_cc_arbiter_pkg.sv
// Shared definitions for the completer-completion stream arbiter:
// FSM encodings and the legal source-count range.
package s_axis_cc_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MIN_SRC = 2;
    localparam int MAX_SRC = 8;

    function automatic bit num_src_ok(input int n);
        return (n >= MIN_SRC) && (n <= MAX_SRC);
    endfunction

endpackage

// File: rtl/cc_rr_picker.sv
// Round-robin picker: first asserted request at or above the
// pointer, wrapping modulo NUM_SRC; one-hot result, purely combinational.
module cc_rr_picker
    import s_axis_cc_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_win
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;
    int               w_sum;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_SRC) begin
                w_sum = w_sum - NUM_SRC;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-granular round-robin arbiter sharing one CC AXI-Stream port
// between NUM_SRC completion sources; a grant lasts from first beat to tlast.
module s_axis_cc_arbiter
    import s_axis_cc_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_SRC    = 2
) (
    input  logic                          user_clk,
    input  logic                          user_reset_n,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_SRC*4-1:0]          s_axis_tuser,
    output logic                          m_axis_cc_tvalid,
    input  logic                          m_axis_cc_tready,
    output logic                          m_axis_cc_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_cc_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_cc_tkeep,
    output logic [3:0]                    m_axis_cc_tuser,
    output logic [NUM_SRC-1:0]            grant
);

    localparam int PTR_W = $clog2(NUM_SRC);

    if (!num_src_ok(NUM_SRC)) begin : g_bad_num_src
        $error("s_axis_cc_arbiter: NUM_SRC must be 2..8");
    end

    logic [0:0]            r_state;
    logic [NUM_SRC-1:0]    r_grant;
    logic [PTR_W-1:0]      r_ptr;

    logic [NUM_SRC-1:0]    w_win;
    logic [PTR_W-1:0]      w_gidx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_done;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic [DATA_WIDTH-1:0] w_tdata;
    logic [KEEP_WIDTH-1:0] w_tkeep;
    logic [3:0]            w_tuser;

    cc_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req (s_axis_tvalid),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    // Grant is zero while idle, so the AND-OR mux also blanks the output then.
    always_comb begin
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        w_tdata  = '0;
        w_tkeep  = '0;
        w_tuser  = '0;
        w_gidx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant[i]) begin
                w_tvalid = s_axis_tvalid[i];
                w_tlast  = s_axis_tlast[i];
                w_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_tuser  = s_axis_tuser[i*4 +: 4];
                w_gidx   = PTR_W'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == PTR_W'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;
    assign w_done    = w_tvalid & m_axis_cc_tready & w_tlast;

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant <= w_win;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready    = r_grant & {NUM_SRC{m_axis_cc_tready}};
    assign m_axis_cc_tvalid = w_tvalid;
    assign m_axis_cc_tlast  = w_tlast;
    assign m_axis_cc_tdata  = w_tdata;
    assign m_axis_cc_tkeep  = w_tkeep;
    assign m_axis_cc_tuser  = w_tuser;
    assign grant            = r_grant;

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Directed bench for s_axis_cc_arbiter: a vector table for contention,
// then hand-written fairness, backpressure, valid-gap and reset sequences.
module tb_s_axis_cc_arbiter;

    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int NS = 2;

    logic            clk;
    logic            rst_n;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tready;
    logic [NS-1:0]   s_tlast;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*KW-1:0] s_tkeep;
    logic [NS*4-1:0] s_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [3:0]      m_tuser;
    logic [NS-1:0]   grant;

    int total = 0;
    int bad   = 0;
    int beats = 0;

    s_axis_cc_arbiter #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .NUM_SRC    (NS)
    ) dut (
        .user_clk         (clk),
        .user_reset_n     (rst_n),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tuser     (s_tuser),
        .m_axis_cc_tvalid (m_tvalid),
        .m_axis_cc_tready (m_tready),
        .m_axis_cc_tlast  (m_tlast),
        .m_axis_cc_tdata  (m_tdata),
        .m_axis_cc_tkeep  (m_tkeep),
        .m_axis_cc_tuser  (m_tuser),
        .grant            (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && m_tvalid && m_tready) beats++;
    end

    typedef struct {
        logic [1:0] vld;
        logic [1:0] lst;
        logic       rdy;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ev;
        logic       el;
        logic [7:0] ed;
        logic [1:0] erdy;
        logic [1:0] eg;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic [1:0] vld, logic [1:0] lst, logic rdy,
                                logic [7:0] d0, logic [7:0] d1, logic ev,
                                logic el, logic [7:0] ed, logic [1:0] erdy,
                                logic [1:0] eg);
        vec_t v;
        v.vld = vld; v.lst = lst; v.rdy = rdy; v.d0 = d0; v.d1 = d1;
        v.ev = ev; v.el = el; v.ed = ed; v.erdy = erdy; v.eg = eg;
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] lst,
                         input logic rdy, input logic [7:0] d0,
                         input logic [7:0] d1);
        s_tvalid = vld;
        s_tlast  = lst;
        m_tready = rdy;
        s_tdata  = {120'h0, d1, 120'h0, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks outputs against an expected beat; payload only when valid.
    task automatic expect_out(input string nm, input logic ev, input logic el,
                              input logic [7:0] ed, input logic [1:0] erdy,
                              input logic [1:0] eg);
        check({nm, ".tvalid"}, 128'(m_tvalid), 128'(ev));
        check({nm, ".tready"}, 128'(s_tready), 128'(erdy));
        check({nm, ".grant"}, 128'(grant), 128'(eg));
        if (ev) begin
            check({nm, ".tlast"}, 128'(m_tlast), 128'(el));
            check({nm, ".tdata"}, m_tdata, {120'h0, ed});
            check({nm, ".tuser"}, 128'(m_tuser),
                  (eg == 2'b01) ? 128'd1 : 128'd2);
            check({nm, ".tkeep"}, 128'(m_tkeep), 128'hFFFF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        logic [7:0] ed;

        tbl[0] = mk(2'b11, 2'b00, 1'b1, 8'h01, 8'h11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        tbl[1] = mk(2'b11, 2'b00, 1'b1, 8'h01, 8'h11, 1'b1, 1'b0, 8'h01, 2'b01, 2'b01);
        tbl[2] = mk(2'b11, 2'b00, 1'b1, 8'h02, 8'h11, 1'b1, 1'b0, 8'h02, 2'b01, 2'b01);
        tbl[3] = mk(2'b11, 2'b01, 1'b1, 8'h03, 8'h11, 1'b1, 1'b1, 8'h03, 2'b01, 2'b01);
        tbl[4] = mk(2'b11, 2'b00, 1'b1, 8'h04, 8'h11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        tbl[5] = mk(2'b11, 2'b00, 1'b1, 8'h04, 8'h11, 1'b1, 1'b0, 8'h11, 2'b10, 2'b10);
        tbl[6] = mk(2'b11, 2'b00, 1'b1, 8'h04, 8'h12, 1'b1, 1'b0, 8'h12, 2'b10, 2'b10);
        tbl[7] = mk(2'b11, 2'b10, 1'b1, 8'h04, 8'h13, 1'b1, 1'b1, 8'h13, 2'b10, 2'b10);
        tbl[8] = mk(2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        tbl[9] = mk(2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);

        s_tkeep = '1;
        s_tuser = {4'h2, 4'h1};
        rst_n   = 1'b0;
        drive(2'b11, 2'b11, 1'b1, 8'hEE, 8'hEF);
        repeat (3) step();
        expect_out("reset", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        rst_n = 1'b1;

        // Contention: src0 then src1, one idle cycle between packets
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, tbl[i].lst, tbl[i].rdy, tbl[i].d0, tbl[i].d1);
            #1;
            expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].el,
                       tbl[i].ed, tbl[i].erdy, tbl[i].eg);
            step();
        end

        // Fairness: both sources always valid with single-beat packets
        n0 = 0;
        n1 = 0;
        for (int p = 0; p < 8; p++) begin
            drive(2'b11, 2'b11, 1'b1, 8'hA0 + 8'(p), 8'hB0 + 8'(p));
            #1;
            expect_out($sformatf("fair%0d.idle", p), 1'b0, 1'b0, 8'h00,
                       2'b00, 2'b00);
            step();
            #1;
            ed = (p % 2 == 0) ? 8'hA0 + 8'(p) : 8'hB0 + 8'(p);
            expect_out($sformatf("fair%0d.beat", p), 1'b1, 1'b1, ed,
                       (p % 2 == 0) ? 2'b01 : 2'b10,
                       (p % 2 == 0) ? 2'b01 : 2'b10);
            if (grant == 2'b01) n0++;
            if (grant == 2'b10) n1++;
            step();
        end
        check("fair.count0", 128'(n0), 128'd4);
        check("fair.count1", 128'(n1), 128'd4);

        // Backpressure: src0 4-beat packet, tready low 5 cycles after beat 0
        beats = 0;
        drive(2'b11, 2'b00, 1'b1, 8'h41, 8'hC1);
        #1;
        expect_out("bp.idle", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        #1;
        expect_out("bp.b0", 1'b1, 1'b0, 8'h41, 2'b01, 2'b01);
        step();
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 2'b00, 1'b0, 8'h42, 8'hC2 + 8'(c));
            #1;
            expect_out($sformatf("bp.stall%0d", c), 1'b1, 1'b0, 8'h42,
                       2'b00, 2'b01);
            step();
        end
        drive(2'b11, 2'b00, 1'b1, 8'h42, 8'hC1);
        #1;
        expect_out("bp.b1", 1'b1, 1'b0, 8'h42, 2'b01, 2'b01);
        step();
        drive(2'b11, 2'b00, 1'b1, 8'h43, 8'hC1);
        #1;
        expect_out("bp.b2", 1'b1, 1'b0, 8'h43, 2'b01, 2'b01);
        step();
        drive(2'b11, 2'b01, 1'b1, 8'h44, 8'hC1);
        #1;
        expect_out("bp.b3", 1'b1, 1'b1, 8'h44, 2'b01, 2'b01);
        step();
        check("bp.beats", 128'(beats), 128'd4);

        // Valid gap: src1 owns the port, drops valid 2 cycles, src0 waits
        drive(2'b11, 2'b00, 1'b1, 8'h51, 8'h61);
        #1;
        expect_out("gap.idle", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        #1;
        expect_out("gap.b0", 1'b1, 1'b0, 8'h61, 2'b10, 2'b10);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(2'b01, 2'b01, 1'b1, 8'h51, 8'h62);
            #1;
            expect_out($sformatf("gap.hole%0d", c), 1'b0, 1'b0, 8'h00,
                       2'b10, 2'b10);
            step();
        end
        drive(2'b11, 2'b10, 1'b1, 8'h51, 8'h62);
        #1;
        expect_out("gap.b1", 1'b1, 1'b1, 8'h62, 2'b10, 2'b10);
        step();

        // Single src0 packet leaves the pointer at 1
        drive(2'b01, 2'b01, 1'b1, 8'h71, 8'h00);
        #1;
        expect_out("one.idle", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        #1;
        expect_out("one.b0", 1'b1, 1'b1, 8'h71, 2'b01, 2'b01);
        step();

        // Async reset at beat 2 of a 4-beat src1 packet
        drive(2'b11, 2'b00, 1'b1, 8'h90, 8'h81);
        #1;
        expect_out("rst.idle", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        #1;
        expect_out("rst.b0", 1'b1, 1'b0, 8'h81, 2'b10, 2'b10);
        step();
        drive(2'b11, 2'b00, 1'b1, 8'h90, 8'h82);
        step();
        drive(2'b11, 2'b00, 1'b1, 8'h90, 8'h83);
        #1;
        expect_out("rst.b2", 1'b1, 1'b0, 8'h83, 2'b10, 2'b10);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        rst_n = 1'b1;
        drive(2'b11, 2'b11, 1'b1, 8'h91, 8'h92);
        #1;
        expect_out("post.idle", 1'b0, 1'b0, 8'h00, 2'b00, 2'b00);
        step();
        #1;
        expect_out("post.b0", 1'b1, 1'b1, 8'h91, 2'b01, 2'b01);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
